// File: rtl/counter_updn.sv
// counter_updn: modulo-MODULUS up/down counter with sync clear/load, terminal count and wrap pulse.
// Latency: count and wrap update on the rising clk edge; tc is combinational from count and up.
// Backpressure: none; every edge is consumed. Optional macro COUNTER_SAT_EN selects saturating mode.
module counter_updn #(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // All boundary arithmetic runs one bit wider than the count so that
  // MODULUS = 2**WIDTH is representable and increments cannot overflow.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   MAX_EXT = MOD_EXT - ONE_EXT;
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];

  // Elaboration-time guards on the legal parameter ranges.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_updn: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("counter_updn: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   lv_ext;
  logic             at_top;
  logic             at_bot;
  logic             lv_in_range;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  assign cnt_ext = {1'b0, count};
  assign lv_ext  = {1'b0, load_val};
  assign inc_ext = cnt_ext + ONE_EXT;
  assign dec_ext = cnt_ext - ONE_EXT;

  // The top boundary is where the widened increment reaches MODULUS; the
  // bottom boundary is where the widened decrement borrows into the MSB.
  assign at_top      = (inc_ext == MOD_EXT);
  assign at_bot      = dec_ext[WIDTH];
  assign lv_in_range = (lv_ext < MOD_EXT);

  // Terminal count follows the direction input directly, regardless of en.
  assign tc = up ? at_top : at_bot;

`ifdef COUNTER_SAT_EN

  // Set once a boundary edge has been blocked, so further blocked edges do
  // not re-pulse wrap; cleared by any movement, clear or load.
  logic sat_hit;
  logic next_sat_hit;

  // Next-state selection with clr > load > en priority, saturating at the ends.
  always_comb begin
    next_count   = count;
    next_wrap    = 1'b0;
    next_sat_hit = sat_hit;
    if (clr) begin
      next_count   = '0;
      next_sat_hit = 1'b0;
    end else if (load) begin
      next_count   = lv_in_range ? load_val : MAX_CNT;
      next_sat_hit = 1'b0;
    end else if (en) begin
      if (up ? at_top : at_bot) begin
        next_wrap    = ~sat_hit;
        next_sat_hit = 1'b1;
      end else begin
        next_count   = up ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
        next_sat_hit = 1'b0;
      end
    end
  end

  // Saturation memory register, cleared asynchronously with the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_hit <= 1'b0;
    end else begin
      sat_hit <= next_sat_hit;
    end
  end

`else

  // Next-state selection with clr > load > en priority, wrapping at the ends.
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = lv_in_range ? load_val : MAX_CNT;
    end else if (en) begin
      if (up) begin
        next_count = at_top ? '0 : inc_ext[WIDTH-1:0];
        next_wrap  = at_top;
      end else begin
        next_count = at_bot ? MAX_CNT : dec_ext[WIDTH-1:0];
        next_wrap  = at_bot;
      end
    end
  end

`endif

  // Count and wrap registers; reset forces both to zero immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_counter_updn.sv
// tb_counter_updn: checks counter_updn (200-state and 16-state instances) against an
// integer reference model with directed boundary cases followed by random stimulus.
// Build with +define+COUNTER_SAT_EN to check the saturating variant.
module tb_counter_updn;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [3:0] load_val4;
  logic [7:0] count8;
  logic       tc8;
  logic       wrap8;
  logic [3:0] count4;
  logic       tc4;
  logic       wrap4;

  assign load_val4 = load_val[3:0];

  counter_updn #(.WIDTH(8), .MODULUS(200)) u_dut8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count8), .tc(tc8), .wrap(wrap8)
  );

  counter_updn #(.WIDTH(4), .MODULUS(16)) u_dut4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val4), .count(count4), .tc(tc4), .wrap(wrap4)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers per instance.
  int unsigned m_cnt8 = 0, m_cnt4 = 0;
  bit          m_wrap8 = 0, m_wrap4 = 0;
  bit          m_sat8 = 0, m_sat4 = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock edge of the counter, written from the rules with modulo arithmetic.
  function automatic void model_edge(input int unsigned modulus, input bit e, input bit u,
                                     input bit c, input bit l, input int unsigned lv,
                                     inout int unsigned cnt, inout bit wrp, inout bit sat);
    bit crossing;
    wrp = 1'b0;
    if (c) begin
      cnt = 0;
      sat = 1'b0;
    end else if (l) begin
      cnt = (lv < modulus) ? lv : modulus - 1;
      sat = 1'b0;
    end else if (e) begin
      crossing = u ? (cnt == modulus - 1) : (cnt == 0);
`ifdef COUNTER_SAT_EN
      if (crossing) begin
        wrp = !sat;
        sat = 1'b1;
      end else begin
        cnt = u ? cnt + 1 : cnt - 1;
        sat = 1'b0;
      end
`else
      cnt = u ? (cnt + 1) % modulus : (cnt + modulus - 1) % modulus;
      wrp = crossing;
`endif
    end
  endfunction

  function automatic bit model_tc(input int unsigned modulus, input int unsigned cnt, input bit u);
    return u ? (cnt == modulus - 1) : (cnt == 0);
  endfunction

  task automatic model_reset();
    m_cnt8 = 0; m_wrap8 = 0; m_sat8 = 0;
    m_cnt4 = 0; m_wrap4 = 0; m_sat4 = 0;
  endtask

  // Advance one edge: model follows the inputs present at the edge, then compare just after.
  task automatic step();
    @(posedge clk);
    model_edge(200, en, up, clr, load, load_val, m_cnt8, m_wrap8, m_sat8);
    model_edge(16, en, up, clr, load, load_val4, m_cnt4, m_wrap4, m_sat4);
    #1;
    chk("count8", count8, m_cnt8);
    chk("wrap8", wrap8, m_wrap8);
    chk("tc8", tc8, model_tc(200, m_cnt8, up));
    chk("count4", count4, m_cnt4);
    chk("wrap4", wrap4, m_wrap4);
    chk("tc4", tc4, model_tc(16, m_cnt4, up));
  endtask

  int wraps;
  int unsigned c0;

  initial begin
    // Reset state, and tc following up while in reset.
    model_reset();
    #3;
    chk("rst_count8", count8, 0);
    chk("rst_wrap8", wrap8, 0);
    chk("rst_tc_up", tc8, 0);
    up = 1'b0;
    #1;
    chk("rst_tc_down", tc8, 1);
    chk("rst_tc4_down", tc4, 1);
    up = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Full count-up sweep through one wrap.
    en = 1'b1; up = 1'b1; wraps = 0;
    repeat (200) begin
      step();
      if (wrap8) wraps++;
    end
    chk("sweep_end", count8, 0);
    chk("sweep_wraps", wraps, 1);

    // Down from zero wraps to the top, then three more edges.
    up = 1'b0;
    step();
    chk("down_wrap_cnt", count8, 199);
    chk("down_wrap_pulse", wrap8, 1);
    repeat (3) step();
    chk("down_3", count8, 196);
    chk("down_wrap_gone", wrap8, 0);

    // Out-of-range load clamps; clr wins over load and en.
    en = 1'b0; load = 1'b1; load_val = 8'd250;
    step();
    chk("load_clamp", count8, 199);
    clr = 1'b1; en = 1'b1;
    step();
    chk("clr_prio", count8, 0);
    clr = 1'b0; load = 1'b0;

    // Asynchronous reset between edges at 57.
    en = 1'b0; load = 1'b1; load_val = 8'd57;
    step();
    chk("load57", count8, 57);
    load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_cnt", count8, 0);
    chk("async_rst_wrap", wrap8, 0);
    chk("async_rst_cnt4", count4, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b1; up = 1'b1;
    step();
    chk("resume", count8, 1);

    // Top boundary behaviour at 199.
    en = 1'b0; load = 1'b1; load_val = 8'd199;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
`ifdef COUNTER_SAT_EN
    wraps = 0;
    repeat (5) begin
      step();
      if (wrap8) wraps++;
    end
    chk("sat_hold", count8, 199);
    chk("sat_wraps", wraps, 1);
    up = 1'b0;
    step();
    chk("sat_leave", count8, 198);
`else
    step();
    chk("top_wrap_cnt", count8, 0);
    chk("top_wrap_pulse", wrap8, 1);
`endif

    // 4-bit full-range instance: boundary at 15, then half-rate counting.
    en = 1'b0; load = 1'b1; load_val = 8'd15;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
`ifdef COUNTER_SAT_EN
    chk("w4_top", count4, 15);
`else
    chk("w4_top", count4, 0);
`endif
    chk("w4_wrap", wrap4, 1);
    en = 1'b0; load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    c0 = m_cnt4;
    for (int i = 0; i < 8; i++) begin
      en = (i % 2 == 0);
      step();
    end
    chk("w4_half_rate", count4, c0 + 4);

    // Random stimulus, with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      clr      = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 7) < 5) ? (i % 400 < 200) : $urandom_range(0, 1) == 1;
      load_val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        chk("rand_rst_cnt8", count8, 0);
        chk("rand_rst_cnt4", count4, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_updn.md
COUNTER_UPDN -- requirements
Module: counter_updn

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the count register width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter MODULUS, default 256, giving the count range 0..MODULUS-1 (legal range 2..2**WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: count enable.
REQ-006 The module SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 The module SHALL have port clr, input, 1 bit: synchronous clear to 0.
REQ-008 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 The module SHALL have port load_val, input, WIDTH bits: value loaded when load=1.
REQ-010 The module SHALL have port count, output, WIDTH bits: registered current count.
REQ-011 The module SHALL have port tc, output, 1 bit: combinational terminal count.
REQ-012 The module SHALL have port wrap, output, 1 bit: registered one-cycle pulse marking a boundary event.

Function
REQ-013 Per-edge priority SHALL be clr > load > en, with hold when none of these is asserted.
REQ-014 clr=1 SHALL set count to 0 and wrap to 0, regardless of load and en.
REQ-015 load=1 (clr=0) SHALL set count to load_val if load_val<MODULUS, else to MODULUS-1; wrap SHALL be 0.
REQ-016 en=1, up=1, count<MODULUS-1 SHALL give count+1; en=1, up=0, count>0 SHALL give count-1.
REQ-017 en=1, up=1, count=MODULUS-1 SHALL give count=0 with wrap=1 the next cycle (without COUNTER_SAT_EN).
REQ-018 en=1, up=0, count=0 SHALL give count=MODULUS-1 with wrap=1 the next cycle (without COUNTER_SAT_EN).
REQ-019 tc SHALL be 1 when (up=1 and count=MODULUS-1) or (up=0 and count=0); it SHALL follow up combinationally and SHALL be independent of en.
REQ-020 wrap SHALL be 1 for exactly the one cycle following the boundary edge and 0 otherwise, including under sustained en.
REQ-021 A direction change SHALL take effect on the same edge as it is sampled, with no extra latency.
REQ-022 Next-count arithmetic SHALL be done at WIDTH+1 bits so that MODULUS=2**WIDTH wraps correctly, with no intermediate overflow.
REQ-023 When en=0 and clr=0 and load=0, count SHALL hold and wrap SHALL be 0.

Reset
REQ-024 reset=0 SHALL immediately and asynchronously force count=0 and wrap=0, independent of clk.
REQ-025 Reset asserted mid-count SHALL abort operation, and the first enabled edge after deassertion SHALL count from 0.
REQ-026 Reset deassertion SHALL be released to logic so that no edge is lost or doubled.
REQ-027 tc after reset SHALL be 0 when up=1 and 1 when up=0, for MODULUS>=2.

Configuration
REQ-028 Macro COUNTER_SAT_EN defined SHALL select saturating mode: at the boundary (REQ-017, REQ-018) count holds at MODULUS-1 (up) or 0 (down), and wrap pulses once on the first blocked edge only.
REQ-029 Under COUNTER_SAT_EN, wrap SHALL not re-pulse while the count stays saturated; it re-arms after any count change, clr, or load.
REQ-030 Without COUNTER_SAT_EN, the counter SHALL wrap as in REQ-017 and REQ-018; no saturating logic SHALL be present.

Verification
REQ-031 WIDTH=8, MODULUS=200: reset, then en=1 and up=1 for 200 cycles -> count 0..199 then 0; wrap=1 exactly once, on the cycle count=0; tc=1 while count=199.
REQ-032 WIDTH=8, MODULUS=200: from count=0, en=1, up=0 -> next count=199, wrap=1; after 3 further edges count=196.
REQ-033 load_val=250 with MODULUS=200 -> count=199. Then clr=1, load=1, en=1 on the same edge -> count=0.
REQ-034 reset driven low between edges at count=57 -> count=0 before the next clk edge; wrap=0; counting resumes from 0.
REQ-035 With COUNTER_SAT_EN: count=199, en=1, up=1 for 5 cycles -> count stays 199 and wrap pulses once; then up=0 -> 198.
REQ-036 WIDTH=4, MODULUS=16: en=1, up=1 from 15 -> count=0 with wrap=1; toggling en every cycle halves the count rate.
